// File: rtl/umi_sb_pkg.sv
// umi_sb_pkg: shared types, widths and flit-count helper for the UMI/Switchboard burst adapter
package umi_sb_pkg;
  localparam int SB_DEST_W = 32;
  typedef enum logic {IDLE, SEND} tx_state_t;
  typedef enum logic [1:0] {COLLECT, HOLD, DROP} rx_state_t;
  function automatic int nflits(input int pw, input int sb_dw);
    return (pw + sb_dw - 1) / sb_dw;
  endfunction
endpackage

// File: rtl/umi_sb_burst_adapter_if.sv
// umi_sb_burst_adapter_if: bundle of UMI in/out and Switchboard tx/rx signals
// slave modport: adapter side (consumes umi_in and sb_rx, produces sb_tx and umi_out)
// master modport: user/queue side, mirror of slave
interface umi_sb_burst_adapter_if #(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int SB_DW = 128
);
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr;
  logic [AW-1:0] umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic umi_in_valid;
  logic umi_in_ready;
  logic [SB_DW-1:0] sb_tx_data;
  logic [umi_sb_pkg::SB_DEST_W-1:0] sb_tx_dest;
  logic sb_tx_last;
  logic sb_tx_valid;
  logic sb_tx_ready;
  logic [SB_DW-1:0] sb_rx_data;
  logic sb_rx_last;
  logic sb_rx_valid;
  logic sb_rx_ready;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic umi_out_valid;
  logic umi_out_ready;
  modport slave (
    input umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data, umi_in_valid,
    output umi_in_ready,
    output sb_tx_data, sb_tx_dest, sb_tx_last, sb_tx_valid,
    input sb_tx_ready,
    input sb_rx_data, sb_rx_last, sb_rx_valid,
    output sb_rx_ready,
    output umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data, umi_out_valid,
    input umi_out_ready
  );
  modport master (
    output umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data, umi_in_valid,
    input umi_in_ready,
    input sb_tx_data, sb_tx_dest, sb_tx_last, sb_tx_valid,
    output sb_tx_ready,
    output sb_rx_data, sb_rx_last, sb_rx_valid,
    input sb_rx_ready,
    input umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data, umi_out_valid,
    output umi_out_ready
  );
endinterface

// File: rtl/umi_sb_deserializer.sv
// umi_sb_deserializer: reassembles Switchboard flits into a packed UMI packet and checks burst length
// ports: i_data/i_last/i_valid/o_ready flit input; o_pkt/o_valid/i_ready packet output;
// o_err_short/o_err_long one-cycle pulses for early-ended and overlong bursts
module umi_sb_deserializer
  import umi_sb_pkg::*;
#(
  parameter int PW = 416,
  parameter int SB_DW = 128
) (
  input  logic clk,
  input  logic nreset,
  input  logic [SB_DW-1:0] i_data,
  input  logic i_last,
  input  logic i_valid,
  output logic o_ready,
  output logic [PW-1:0] o_pkt,
  output logic o_valid,
  input  logic i_ready,
  output logic o_err_short,
  output logic o_err_long
);
  localparam int NF = nflits(PW, SB_DW);
  localparam int CNTW = NF > 1 ? $clog2(NF) : 1;
  rx_state_t r_state;
  logic [CNTW-1:0] r_cnt;
  logic [PW-1:0] r_pkt;
  logic r_err_short, r_err_long;
  logic w_full, w_wr;
  assign o_ready = r_state != HOLD;
  assign o_valid = r_state == HOLD;
  assign o_pkt = r_pkt;
  assign o_err_short = r_err_short;
  assign o_err_long = r_err_long;
  assign w_full = r_cnt == CNTW'(NF - 1);
  assign w_wr = i_valid && r_state == COLLECT;
  // the final slot keeps only the bits below PW; padding above is ignored
  for (genvar j = 0; j < NF; j++) begin : g_slot
    localparam int W = PW - j * SB_DW < SB_DW ? PW - j * SB_DW : SB_DW;
    always_ff @(posedge clk or negedge nreset)
      if (!nreset) r_pkt[j*SB_DW +: W] <= '0;
      else if (w_wr && r_cnt == CNTW'(j)) r_pkt[j*SB_DW +: W] <= i_data[W-1:0];
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_state <= COLLECT;
      r_cnt <= '0;
      r_err_short <= 1'b0;
      r_err_long <= 1'b0;
    end else begin
      r_err_short <= 1'b0;
      r_err_long <= 1'b0;
      case (r_state)
        COLLECT: if (i_valid) begin
          r_cnt <= (i_last || w_full) ? '0 : r_cnt + 1'b1;
          if (i_last && w_full) r_state <= HOLD;
          else if (i_last) r_err_short <= 1'b1;
          else if (w_full) begin
            r_err_long <= 1'b1;
            r_state <= DROP;
          end
        end
        DROP: if (i_valid && i_last) r_state <= COLLECT;
        HOLD: if (i_ready) r_state <= COLLECT;
        default: r_state <= COLLECT;
      endcase
    end
endmodule

// File: rtl/umi_sb_burst_adapter.sv
// umi_sb_burst_adapter: bidirectional UMI <-> Switchboard adapter with multi-flit bursts
// ports: clk, nreset (async active-low); bus (slave modport) carries umi_in, sb_tx, sb_rx, umi_out;
// err_short/err_long RX burst-length error pulses
// optional: define UMI_SB_BURST_ERRCNT_EN to add err_count[15:0], a saturating error counter
module umi_sb_burst_adapter
  import umi_sb_pkg::*;
#(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int SB_DW = 128,
  parameter int DEST_LSB = 40,
  parameter int DEST_W = 16
) (
  input  logic clk,
  input  logic nreset,
  umi_sb_burst_adapter_if.slave bus,
  output logic err_short,
  output logic err_long
`ifdef UMI_SB_BURST_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);
  localparam int PW = DW + 2 * AW + CW;
  localparam int NF = nflits(PW, SB_DW);
  localparam int SHW = NF * SB_DW;
  localparam int CNTW = NF > 1 ? $clog2(NF) : 1;
  tx_state_t r_state;
  logic [SHW-1:0] r_shreg;
  logic [CNTW-1:0] r_cnt;
  logic [SB_DEST_W-1:0] r_dest;
  logic [PW-1:0] w_rx_pkt;
  logic w_send, w_last, w_acc;
  assign w_send = r_state == SEND;
  assign w_last = w_send && r_cnt == CNTW'(NF - 1);
  // accepting during the final flit reloads the shift register with no idle cycle
  assign bus.umi_in_ready = !w_send || (w_last && bus.sb_tx_ready);
  assign w_acc = bus.umi_in_valid && bus.umi_in_ready;
  assign bus.sb_tx_valid = w_send;
  assign bus.sb_tx_last = w_last;
  assign bus.sb_tx_data = r_shreg[SB_DW-1:0];
  assign bus.sb_tx_dest = r_dest;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt <= '0;
      r_dest <= '0;
    end else if (w_acc) begin
      r_state <= SEND;
      r_shreg <= SHW'({bus.umi_in_data, bus.umi_in_srcaddr, bus.umi_in_dstaddr, bus.umi_in_cmd});
      r_cnt <= '0;
      r_dest <= SB_DEST_W'(bus.umi_in_dstaddr[DEST_LSB +: DEST_W]);
    end else if (w_send && bus.sb_tx_ready) begin
      r_state <= w_last ? IDLE : SEND;
      r_shreg <= r_shreg >> SB_DW;
      r_cnt <= r_cnt + 1'b1;
    end
  umi_sb_deserializer #(.PW(PW), .SB_DW(SB_DW)) u_deser (
    .clk(clk),
    .nreset(nreset),
    .i_data(bus.sb_rx_data),
    .i_last(bus.sb_rx_last),
    .i_valid(bus.sb_rx_valid),
    .o_ready(bus.sb_rx_ready),
    .o_pkt(w_rx_pkt),
    .o_valid(bus.umi_out_valid),
    .i_ready(bus.umi_out_ready),
    .o_err_short(err_short),
    .o_err_long(err_long)
  );
  assign bus.umi_out_cmd = w_rx_pkt[CW-1:0];
  assign bus.umi_out_dstaddr = w_rx_pkt[CW +: AW];
  assign bus.umi_out_srcaddr = w_rx_pkt[CW+AW +: AW];
  assign bus.umi_out_data = w_rx_pkt[CW+2*AW +: DW];
`ifdef UMI_SB_BURST_ERRCNT_EN
  logic [15:0] r_err_count;
  assign err_count = r_err_count;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) r_err_count <= '0;
    else if ((err_short || err_long) && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 1'b1;
`endif
endmodule

// File: tb/tb_umi_sb_burst_adapter.sv
// tb_umi_sb_burst_adapter: randomized self-checking bench with a queue-based packet/flit reference model
module tb_umi_sb_burst_adapter;
  localparam int DW = 256, AW = 64, CW = 32, SB_DW = 128, DEST_LSB = 40, DEST_W = 16;
  localparam int PW = DW + 2 * AW + CW;
  localparam int NF = (PW + SB_DW - 1) / SB_DW;
  localparam int WW = NF * SB_DW;
  typedef struct {
    logic [SB_DW-1:0] data;
    logic last;
    logic [31:0] dest;
  } flit_t;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic err_short, err_long;
`ifdef UMI_SB_BURST_ERRCNT_EN
  logic [15:0] err_count;
`endif
  logic tx_ready = 1'b0, rx_valid = 1'b0, rx_last = 1'b0;
  logic [SB_DW-1:0] rx_data = '0;
  logic loop = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int obs_short = 0, obs_long = 0, exp_short = 0, exp_long = 0, n_flits = 0, n_out = 0;
  flit_t tx_exp[$];
  logic [SB_DW-1:0] rx_buf[$];
  logic [PW-1:0] out_exp[$], sent[$];
  logic [SB_DW-1:0] last_flit = '0;
  logic [WW-1:0] m_w;
  logic [PW-1:0] m_got;
  flit_t m_f;
  always #5 clk = ~clk;
  umi_sb_burst_adapter_if #(.DW(DW), .AW(AW), .CW(CW), .SB_DW(SB_DW)) bus ();
  assign bus.sb_tx_ready = loop ? bus.sb_rx_ready : tx_ready;
  assign bus.sb_rx_valid = loop ? bus.sb_tx_valid : rx_valid;
  assign bus.sb_rx_last = loop ? bus.sb_tx_last : rx_last;
  assign bus.sb_rx_data = loop ? bus.sb_tx_data : rx_data;
  umi_sb_burst_adapter #(
    .DW(DW), .AW(AW), .CW(CW), .SB_DW(SB_DW), .DEST_LSB(DEST_LSB), .DEST_W(DEST_W)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus.slave),
    .err_short(err_short),
    .err_long(err_long)
`ifdef UMI_SB_BURST_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction
  function automatic logic [DW-1:0] rdw();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < DW / 32; i++) v = (v << 32) | DW'($urandom);
    return v;
  endfunction
  // reference model: packets split lsb-first into NF flits, bursts classified by length
  always @(negedge clk) if (nreset) begin
    if (bus.sb_tx_valid && bus.sb_tx_ready) begin
      n_flits++;
      if (bus.sb_tx_last) last_flit = bus.sb_tx_data;
      if (tx_exp.size() == 0) check("tx_unexpected", 512'(1), 512'(0));
      else begin
        m_f = tx_exp.pop_front();
        check("tx_data", 512'(bus.sb_tx_data), 512'(m_f.data));
        check("tx_last", 512'(bus.sb_tx_last), 512'(m_f.last));
        check("tx_dest", 512'(bus.sb_tx_dest), 512'(m_f.dest));
      end
    end
    if (bus.umi_in_valid && bus.umi_in_ready) begin
      m_w = WW'({bus.umi_in_data, bus.umi_in_srcaddr, bus.umi_in_dstaddr, bus.umi_in_cmd});
      for (int i = 0; i < NF; i++) begin
        m_f.data = m_w[i*SB_DW +: SB_DW];
        m_f.last = (i == NF - 1);
        m_f.dest = 32'((bus.umi_in_dstaddr >> DEST_LSB) & ((64'd1 << DEST_W) - 64'd1));
        tx_exp.push_back(m_f);
      end
      if (loop) sent.push_back(m_w[PW-1:0]);
    end
    if (bus.umi_out_valid && bus.umi_out_ready) begin
      n_out++;
      m_got = {bus.umi_out_data, bus.umi_out_srcaddr, bus.umi_out_dstaddr, bus.umi_out_cmd};
      if (out_exp.size() == 0) check("rx_unexpected", 512'(1), 512'(0));
      else check("rx_pkt", 512'(m_got), 512'(out_exp.pop_front()));
      if (loop) begin
        if (sent.size() == 0) check("loop_unexpected", 512'(1), 512'(0));
        else check("loop_pkt", 512'(m_got), 512'(sent.pop_front()));
      end
    end
    if (bus.sb_rx_valid && bus.sb_rx_ready) begin
      rx_buf.push_back(bus.sb_rx_data);
      if (bus.sb_rx_last) begin
        if (rx_buf.size() == NF) begin
          m_w = '0;
          for (int i = 0; i < NF; i++) m_w[i*SB_DW +: SB_DW] = rx_buf[i];
          out_exp.push_back(m_w[PW-1:0]);
        end else if (rx_buf.size() < NF) exp_short++;
        else exp_long++;
        rx_buf.delete();
      end
    end
    if (err_short) obs_short++;
    if (err_long) obs_long++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [CW-1:0] c, input logic [AW-1:0] d, input logic [AW-1:0] s,
                      input logic [DW-1:0] x);
    logic acc = 1'b0;
    bus.umi_in_cmd = c;
    bus.umi_in_dstaddr = d;
    bus.umi_in_srcaddr = s;
    bus.umi_in_data = x;
    bus.umi_in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.umi_in_ready;
      tick();
    end
    bus.umi_in_valid = 1'b0;
    if (!acc) check("send_timeout", 512'(0), 512'(1));
  endtask
  task automatic rx_burst(input int len);
    logic acc;
    for (int j = 0; j < len; j++) begin
      rx_data = SB_DW'({$urandom, $urandom, $urandom, $urandom});
      rx_last = (j == len - 1);
      rx_valid = 1'b1;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
        @(negedge clk);
        acc = bus.sb_rx_ready;
        tick();
      end
      if (!acc) check("rx_timeout", 512'(0), 512'(1));
    end
    rx_valid = 1'b0;
    rx_last = 1'b0;
  endtask
  bit run;
  int base, base_out, s0, l0;
  logic [8:0] vmask, lmask;
  logic [SB_DW-1:0] p_data;
  logic p_last;
  logic [31:0] p_dest;
  initial begin
    bus.umi_in_valid = 1'b0;
    bus.umi_in_cmd = '0;
    bus.umi_in_dstaddr = '0;
    bus.umi_in_srcaddr = '0;
    bus.umi_in_data = '0;
    bus.umi_out_ready = 1'b0;
    #1 nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 512'(bus.sb_tx_valid), 512'(0));
    check("rst_tx_last", 512'(bus.sb_tx_last), 512'(0));
    check("rst_tx_dest", 512'(bus.sb_tx_dest), 512'(0));
    check("rst_out_valid", 512'(bus.umi_out_valid), 512'(0));
    check("rst_err", 512'({err_short, err_long}), 512'(0));
    nreset = 1'b1;
    tick();
    check("rst_in_ready", 512'(bus.umi_in_ready), 512'(1));
    check("rst_rx_ready", 512'(bus.sb_rx_ready), 512'(1));
`ifdef UMI_SB_BURST_ERRCNT_EN
    check("rst_err_count", 512'(err_count), 512'(0));
`endif
    // single packet, full-rate sink
    tx_ready = 1'b1;
    base = n_flits;
    send(32'h3, 64'h00AB_CD00_0000_1000, r64(), rdw());
    check("t1_latency", 512'(bus.sb_tx_valid), 512'(1));
    check("t1_dest", 512'(bus.sb_tx_dest), 512'(32'h0000_ABCD));
    repeat (5) tick();
    check("t1_flits", 512'(n_flits - base), 512'(NF));
    check("t1_pad_zero", 512'(last_flit >> (PW % SB_DW)), 512'(0));
    // alternating backpressure
    tx_ready = 1'b0;
    send(r64()[CW-1:0], r64(), r64(), rdw());
    base = n_flits;
    for (int c = 0; c < 7; c++) begin
      tx_ready = (c % 2 == 0);
      @(negedge clk);
      check("t2_valid", 512'(bus.sb_tx_valid), 512'(1));
      check("t2_in_ready", 512'(bus.umi_in_ready), 512'(c == 6));
      if (c % 2 == 0 && c > 0) begin
        check("t2_hold_data", 512'(bus.sb_tx_data), 512'(p_data));
        check("t2_hold_last", 512'(bus.sb_tx_last), 512'(p_last));
        check("t2_hold_dest", 512'(bus.sb_tx_dest), 512'(p_dest));
      end
      p_data = bus.sb_tx_data;
      p_last = bus.sb_tx_last;
      p_dest = bus.sb_tx_dest;
      tick();
    end
    check("t2_flits", 512'(n_flits - base), 512'(NF));
    tx_ready = 1'b1;
    tick();
    // back-to-back packets
    send(r64()[CW-1:0], r64(), r64(), rdw());
    fork
      send(r64()[CW-1:0], r64(), r64(), rdw());
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        vmask[i] = bus.sb_tx_valid;
        lmask[i] = bus.sb_tx_last;
      end
    join
    check("t3_valid", 512'(vmask), 512'(9'h0FF));
    check("t3_last", 512'(lmask), 512'(9'h088));
    repeat (3) tick();
    // loopback with random output backpressure
    loop = 1'b1;
    run = 1'b1;
    base_out = n_out;
    s0 = obs_short;
    l0 = obs_long;
    fork
      while (run) begin
        bus.umi_out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    join_none
    for (int p = 0; p < 100; p++) begin
      send(r64()[CW-1:0], r64(), r64(), rdw());
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int t = 0; t < 5000 && n_out - base_out < 100; t++) tick();
    run = 1'b0;
    check("t4_delivered", 512'(n_out - base_out), 512'(100));
    check("t4_no_short", 512'(obs_short - s0), 512'(0));
    check("t4_no_long", 512'(obs_long - l0), 512'(0));
    repeat (2) tick();
    loop = 1'b0;
    bus.umi_out_ready = 1'b1;
    tick();
    // faulty bursts then a good one
    base_out = n_out;
    s0 = obs_short;
    l0 = obs_long;
    rx_burst(2);
    check("t5_short_pulse", 512'(err_short), 512'(1));
    rx_burst(6);
    rx_burst(NF);
    check("t5_latency", 512'(bus.umi_out_valid), 512'(1));
    repeat (3) tick();
    check("t5_short", 512'(obs_short - s0), 512'(1));
    check("t5_long", 512'(obs_long - l0), 512'(1));
    check("t5_short_model", 512'(obs_short), 512'(exp_short));
    check("t5_long_model", 512'(obs_long), 512'(exp_long));
    check("t5_delivered", 512'(n_out - base_out), 512'(1));
`ifdef UMI_SB_BURST_ERRCNT_EN
    check("t5_err_count", 512'(err_count), 512'(2));
`endif
    // reset mid-burst
    base = n_flits;
    send(r64()[CW-1:0], r64(), r64(), rdw());
    tick();
    tick();
    check("t6_partial", 512'(n_flits - base), 512'(2));
    nreset = 1'b0;
    tx_exp.delete();
    rx_buf.delete();
    out_exp.delete();
    #1;
    check("t6_valid_async", 512'(bus.sb_tx_valid), 512'(0));
    check("t6_last_async", 512'(bus.sb_tx_last), 512'(0));
    check("t6_dest_async", 512'(bus.sb_tx_dest), 512'(0));
    tick();
    nreset = 1'b1;
    tick();
    check("t6_in_ready", 512'(bus.umi_in_ready), 512'(1));
    check("t6_rx_ready", 512'(bus.sb_rx_ready), 512'(1));
    base = n_flits;
    send(r64()[CW-1:0], r64(), r64(), rdw());
    repeat (6) tick();
    check("t6_flits", 512'(n_flits - base), 512'(NF));
    check("t6_drained", 512'(tx_exp.size()), 512'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/umi_sb_burst_adapter.md
Name: umi_sb_burst_adapter

Overview:
Bidirectional UMI-to-Switchboard adapter with burst (multi-flit) support, for use when the packed UMI packet is wider than the Switchboard flit width.
- TX path serialises one UMI transaction into ceil(PW/SB_DW) flits and asserts last on the final flit.
- RX path reassembles flits into UMI transactions and checks burst length.
- Sits between user UMI logic and sb_fpga_queues, one instance per queue pair.
- Removes the single-flit restriction: tx_last is no longer tied high.

Parameters:
DW, 256, UMI data width
AW, 64, UMI address width
CW, 32, UMI command width
SB_DW, 128, Switchboard flit data width (1..PW)
DEST_LSB, 40, lsb of dstaddr bit-field used as Switchboard destination
DEST_W, 16, destination field width (<=32; DEST_LSB+DEST_W<=AW)

Ports:
clk  in  1  clock
nreset  in  1  reset, asynchronous, active-low
umi_in_cmd  in  CW  TX UMI command
umi_in_dstaddr  in  AW  TX destination address
umi_in_srcaddr  in  AW  TX source address
umi_in_data  in  DW  TX data
umi_in_valid  in  1  TX UMI valid
umi_in_ready  out  1  TX UMI ready
sb_tx_data  out  SB_DW  flit data
sb_tx_dest  out  32  flit destination
sb_tx_last  out  1  final flit of burst
sb_tx_valid  out  1  flit valid
sb_tx_ready  in  1  flit ready
sb_rx_data  in  SB_DW  incoming flit data
sb_rx_last  in  1  incoming final flit
sb_rx_valid  in  1  incoming flit valid
sb_rx_ready  out  1  incoming flit ready
umi_out_cmd/dstaddr/srcaddr/data  out  CW/AW/AW/DW  RX UMI fields
umi_out_valid  out  1  RX UMI valid
umi_out_ready  in  1  RX UMI ready
err_short  out  1  one-cycle pulse: burst ended early
err_long  out  1  one-cycle pulse: burst exceeded NFLITS

Behaviour:
- PW = DW+2*AW+CW. Packed packet is {data, srcaddr, dstaddr, cmd}, with cmd at the lsb. NFLITS = ceil(PW/SB_DW). Flits are sent lsb-first.
- The final flit's bits above PW mod SB_DW are zero; RX ignores them.
- Handshake: a transfer occurs when valid and ready are both high on a clk edge. valid is never dropped and data never changes until the transfer completes.
- TX FSM (IDLE, SEND):
  - IDLE: umi_in_ready=1, sb_tx_valid=0. On accept, latch the packed packet into the shift register, set cnt=0, go to SEND.
  - SEND: sb_tx_valid=1, sb_tx_data=shreg[SB_DW-1:0], sb_tx_last=(cnt==NFLITS-1). On sb_tx_ready, shift right by SB_DW and increment cnt.
  - After the last flit: go to IDLE.
  - umi_in_ready = IDLE | (SEND & sb_tx_last & sb_tx_ready). A simultaneous accept reloads the register and stays in SEND, so back-to-back packets have no bubble.
  - sb_tx_dest = zero-extended dstaddr[DEST_LSB+:DEST_W], latched with the packet and constant for the whole burst.
  - NFLITS==1: single register stage with sb_tx_last=1 always.
- RX FSM (COLLECT, HOLD, DROP):
  - COLLECT: sb_rx_ready=1. Each flit is written to slot cnt.
    - last && cnt==NFLITS-1: go to HOLD.
    - last && cnt<NFLITS-1: pulse err_short, discard the partial packet, cnt=0, stay in COLLECT.
    - !last && cnt==NFLITS-1: pulse err_long, go to DROP.
  - DROP: sb_rx_ready=1. Discard flits up to and including the next last flit, then go to COLLECT with cnt=0.
  - HOLD: umi_out_valid=1, sb_rx_ready=0. On umi_out_ready go to COLLECT.
- Latency:
  - TX: first flit appears 1 cycle after the UMI accept.
  - RX: umi_out_valid rises 1 cycle after the last-flit accept.
- Reset (async, any state, mid-burst included):
  - FSMs return to IDLE/COLLECT, counters and shift registers clear.
  - sb_tx_valid=0, umi_out_valid=0, err_*=0, sb_tx_last=0, sb_tx_dest=0.
  - umi_in_ready=1 and sb_rx_ready=1 once nreset deasserts.
  - A partial burst is lost; no flush is performed.
- The TX and RX paths are fully independent. Simultaneous activity on both is allowed.

Optional Feature:
UMI_SB_BURST_ERRCNT_EN
- Defined: adds output err_count[15:0], which increments on each err_short or err_long pulse and saturates at 16'hFFFF. Reset value 0. If both pulses occur in the same cycle, it increments by 1 only.
- Undefined: port absent. Error pulses only.

Decomposition:
- Package umi_sb_pkg holds:
  - function nflits(pw, sb_dw)
  - typedefs tx_state_t {IDLE, SEND} and rx_state_t {COLLECT, HOLD, DROP}
  - localparam SB_DEST_W=32
- One sub-module, umi_sb_deserializer, implements the RX FSM. The top level holds the TX serializer and field packing/unpacking.

Test Plan:
1. Single TX packet at defaults (NFLITS=4). Stimulus: cmd=32'h3, dstaddr=64'h00AB_CD00_0000_1000. Required: 4 flits, last only on flit 3, dest=32'h0000_ABCD, flit3[127:32]==0.
2. TX backpressure, sb_tx_ready pattern 1,0,1,0,... Required: 4 flits over 8 cycles, data/last/dest stable while stalled, umi_in_ready=0 until the final accept.
3. Two back-to-back TX packets, sb_tx_ready=1. Required: 8 consecutive valid cycles, last on cycles 4 and 8, no bubble.
4. TX looped to RX with 100 random packets and random umi_out_ready. Required: umi_out fields equal the inputs in order, no err pulses.
5. RX fault bursts. Stimulus: a 2-flit burst with last on flit 2, then a 6-flit burst, then a good 4-flit burst. Required: err_short pulse, then err_long pulse, no umi_out for either faulty burst, the good packet delivered; err_count=2 when UMI_SB_BURST_ERRCNT_EN is defined.
6. nreset asserted after 2 of 4 TX flits. Required: sb_tx_valid=0 immediately; after release, a new packet starts from flit 0 with correct data.
